// File: rtl/pc_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_hazard_ctrl
//  Description : Next-PC selection and pipeline hazard control for a 5-stage
//                core. Handles load-use stalls, instruction/data memory wait
//                states and taken branches resolved in ID. A branch that
//                resolves while a fetch is outstanding is parked as a deferred
//                redirect and applied when the fetch completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_hazard_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_cur_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IWAIT = 2'd1,
    ST_DWAIT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        pending_q;
  logic        pending_d;
  logic [31:0] target_q;
  logic [31:0] target_d;
  logic [31:0] pc_plus4;
  logic        dwait_cond;
  logic        load_use;

  assign pc_plus4   = pc_cur_i + 32'd4;
  assign dwait_cond = dmem_req_i & ~dmem_ready_i;
  // rd==x0 never creates a dependency since x0 is hard-wired to zero.
  assign load_use   = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  assign state_o    = state_q;

  // Prioritised hazard resolution: controls, next PC and next FSM/redirect state.
  always_comb begin
    pc_next_o     = pc_plus4;
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = ST_RUN;
    pending_d     = pending_q;
    target_d      = target_q;

    if (rst_i) begin
      pc_next_o    = RESET_PC;
      ifid_flush_o = 1'b1;
      pending_d    = 1'b0;
      target_d     = 32'd0;
    end else if (dwait_cond) begin
      // Whole pipe frozen; a branch in ID will be re-presented after the wait.
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      pipe_freeze_o = 1'b1;
      state_d       = ST_DWAIT;
    end else if (load_use) begin
      // Branch outcome in ID is not trustworthy until the load data arrives.
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_stall_o   = 1'b1;
      ifid_flush_o = 1'b1;
      state_d      = ST_IWAIT;
      if (branch_taken_i) begin
        pending_d = 1'b1;
        target_d  = branch_target_i;
      end
    end else if (pending_q) begin
      // The fetch that just completed is wrong-path; discard and redirect.
      pc_next_o    = target_q;
      ifid_flush_o = 1'b1;
      pending_d    = 1'b0;
    end else if (branch_taken_i) begin
      pc_next_o    = branch_target_i;
      ifid_flush_o = 1'b1;
    end
  end

  // FSM state and deferred-redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
      target_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (ifid_flush_o && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_hazard_ctrl
//  Description : Directed self-checking bench for pc_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_hazard_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int unsigned CW     = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   pc_cur_i;
  logic          branch_taken_i;
  logic [31:0]   branch_target_i;
  logic          idex_memread_i;
  logic [4:0]    idex_rd_i;
  logic [4:0]    ifid_rs1_i;
  logic [4:0]    ifid_rs2_i;
  logic          imem_ready_i;
  logic          dmem_req_i;
  logic          dmem_ready_i;
  logic [31:0]   pc_next_o;
  logic          pc_stall_o;
  logic          ifid_stall_o;
  logic          ifid_flush_o;
  logic          idex_bubble_o;
  logic          pipe_freeze_o;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  int checks   = 0;
  int failures = 0;

  pc_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pc_cur_i       (pc_cur_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .imem_ready_i   (imem_ready_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_next_o      (pc_next_o),
    .pc_stall_o     (pc_stall_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk = ~clk;

  // Controls packed as {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}.
  logic [4:0] ctl;
  assign ctl = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_i           = 1'b0;
    pc_cur_i        = 32'h0000_0040;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    idex_memread_i  = 1'b0;
    idex_rd_i       = 5'd0;
    ifid_rs1_i      = 5'd0;
    ifid_rs2_i      = 5'd0;
    imem_ready_i    = 1'b1;
    dmem_req_i      = 1'b0;
    dmem_ready_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    tick();
    checks++;
    if (pc_next_o !== RST_PC) begin
      failures++; $display("FAIL reset_pc_next actual=%h expected=%h", pc_next_o, RST_PC);
    end
    checks++;
    if (ctl !== 5'b00100) begin
      failures++; $display("FAIL reset_controls actual=%b expected=%b", ctl, 5'b00100);
    end
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({state_o, stall_cnt_o, flush_cnt_o} !== {2'd0, 4'd0, 4'd0}) begin
      failures++; $display("FAIL reset_state_cnt actual=%0d/%0d/%0d expected=0/0/0",
                           state_o, stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_normal();
    do_reset();
    pc_cur_i = 32'h0000_0040;
    #1;
    checks++;
    if (pc_next_o !== 32'h0000_0044) begin
      failures++; $display("FAIL normal_pc_next actual=%h expected=%h", pc_next_o, 32'h44);
    end
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL normal_controls actual=%b expected=%b", ctl, 5'b00000);
    end
    pc_cur_i = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pc_next_o !== 32'h0000_0000) begin
      failures++; $display("FAIL wrap_pc_next actual=%h expected=%h", pc_next_o, 32'h0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd5;
    ifid_rs1_i     = 5'd1;
    ifid_rs2_i     = 5'd5;
    #1;
    checks++;
    if (ctl !== 5'b11010 || pc_next_o !== 32'h44) begin
      failures++; $display("FAIL load_use_rs2 actual=%b/%h expected=%b/%h", ctl, pc_next_o, 5'b11010, 32'h44);
    end
    tick();
    ifid_rs1_i = 5'd5;
    ifid_rs2_i = 5'd7;
    #1;
    checks++;
    if (ctl !== 5'b11010) begin
      failures++; $display("FAIL load_use_rs1 actual=%b expected=%b", ctl, 5'b11010);
    end
    tick();
    idex_rd_i  = 5'd0;
    ifid_rs1_i = 5'd0;
    ifid_rs2_i = 5'd0;
    #1;
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL load_use_rd0 actual=%b expected=%b", ctl, 5'b00000);
    end
    idex_rd_i      = 5'd5;
    ifid_rs1_i     = 5'd5;
    idex_memread_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL load_use_noload actual=%b expected=%b", ctl, 5'b00000);
    end
    tick();
    checks++;
    if (stall_cnt_o !== 4'd2) begin
      failures++; $display("FAIL load_use_stall_cnt actual=%0d expected=%0d", stall_cnt_o, 2);
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0100;
    #1;
    checks++;
    if (pc_next_o !== 32'h100 || ctl !== 5'b00100) begin
      failures++; $display("FAIL branch_taken actual=%h/%b expected=%h/%b", pc_next_o, ctl, 32'h100, 5'b00100);
    end
    tick();
    branch_taken_i = 1'b0;
    #1;
    checks++;
    if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
      failures++; $display("FAIL branch_counts actual=%0d/%0d expected=1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_dwait();
    do_reset();
    dmem_req_i      = 1'b1;
    dmem_ready_i    = 1'b0;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 5'b11001 || pc_next_o !== 32'h44) begin
        failures++; $display("FAIL dwait_cycle%0d actual=%b/%h expected=%b/%h", i, ctl, pc_next_o, 5'b11001, 32'h44);
      end
      tick();
    end
    checks++;
    if (state_o !== 2'd2 || stall_cnt_o !== 4'd3) begin
      failures++; $display("FAIL dwait_state_cnt actual=%0d/%0d expected=2/3", state_o, stall_cnt_o);
    end
    dmem_ready_i = 1'b1;
    #1;
    checks++;
    if (pc_next_o !== 32'h300 || ctl !== 5'b00100) begin
      failures++; $display("FAIL dwait_release actual=%h/%b expected=%h/%b", pc_next_o, ctl, 32'h300, 5'b00100);
    end
    tick();
    idle();
    #1;
    checks++;
    if (state_o !== 2'd0 || flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd3) begin
      failures++; $display("FAIL dwait_after actual=%0d/%0d/%0d expected=0/1/3", state_o, flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_iwait();
    do_reset();
    imem_ready_i    = 1'b0;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0200;
    #1;
    checks++;
    if (ctl !== 5'b10100) begin
      failures++; $display("FAIL iwait_c1 actual=%b expected=%b", ctl, 5'b10100);
    end
    tick();
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0000_0999;
    #1;
    checks++;
    if (ctl !== 5'b10100 || state_o !== 2'd1) begin
      failures++; $display("FAIL iwait_c2 actual=%b/%0d expected=%b/1", ctl, state_o, 5'b10100);
    end
    tick();
    imem_ready_i = 1'b1;
    #1;
    checks++;
    if (pc_next_o !== 32'h200 || ctl !== 5'b00100) begin
      failures++; $display("FAIL iwait_redirect actual=%h/%b expected=%h/%b", pc_next_o, ctl, 32'h200, 5'b00100);
    end
    tick();
    #1;
    checks++;
    if (pc_next_o !== 32'h44 || ctl !== 5'b00000 || state_o !== 2'd0) begin
      failures++; $display("FAIL iwait_pending_clr actual=%h/%b/%0d expected=%h/%b/0", pc_next_o, ctl, state_o, 32'h44, 5'b00000);
    end
    // Later branch during the same wait replaces the parked target.
    imem_ready_i    = 1'b0;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0500;
    tick();
    branch_target_i = 32'h0000_0600;
    tick();
    branch_taken_i = 1'b0;
    imem_ready_i   = 1'b1;
    #1;
    checks++;
    if (pc_next_o !== 32'h600) begin
      failures++; $display("FAIL iwait_overwrite actual=%h expected=%h", pc_next_o, 32'h600);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    idex_memread_i  = 1'b1;
    idex_rd_i       = 5'd3;
    ifid_rs1_i      = 5'd3;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0800;
    #1;
    checks++;
    if (pc_next_o !== 32'h44 || ctl !== 5'b11010) begin
      failures++; $display("FAIL b2b_loaduse actual=%h/%b expected=%h/%b", pc_next_o, ctl, 32'h44, 5'b11010);
    end
    tick();
    idex_memread_i = 1'b0;
    #1;
    checks++;
    if (pc_next_o !== 32'h800 || ctl !== 5'b00100) begin
      failures++; $display("FAIL b2b_branch actual=%h/%b expected=%h/%b", pc_next_o, ctl, 32'h800, 5'b00100);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_req_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (pc_next_o !== RST_PC || ctl !== 5'b00100) begin
      failures++; $display("FAIL rst_mid_outputs actual=%h/%b expected=%h/%b", pc_next_o, ctl, RST_PC, 5'b00100);
    end
    tick();
    rst_i      = 1'b0;
    dmem_req_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
      failures++; $display("FAIL rst_mid_state actual=%0d/%0d/%0d expected=0/0/0", state_o, stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    idex_memread_i = 1'b1;
    idex_rd_i      = 5'd9;
    ifid_rs2_i     = 5'd9;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checks++;
    if (stall_cnt_o !== 4'd15) begin
      failures++; $display("FAIL stall_saturate actual=%0d expected=%0d", stall_cnt_o, 15);
    end
    idle();
    imem_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checks++;
    if (flush_cnt_o !== 4'd15) begin
      failures++; $display("FAIL flush_saturate actual=%0d expected=%0d", flush_cnt_o, 15);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_normal();
    test_load_use();
    test_branch();
    test_dwait();
    test_iwait();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
